pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_if.sv | 13 +
 rtl/pipe_skid_stage.sv | 95 +++++++++
 tb/tb_pipe_skid_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// rtl/pipe_skid_stage_if.sv - valid/ready stream carrying a data and a control payload
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, data, ctrl, input ready);
  modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid pipeline stage with flush and saturating stall/drop counters
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_skid_stage_if.slave   in_bus,
  pipe_skid_stage_if.master  out_bus,
  output logic [1:0]         level,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_ready_w, out_valid_w;
  logic              in_fire, out_fire;
  logic [CNT_W:0]    drop_sum;
  logic [CNT_W-1:0]  drop_next;

  // Handshake flags come from the state register only, so ready never
  // combinationally follows out_ready or flush.
  assign in_ready_w  = (state != TWO);
  assign out_valid_w = (state != EMPTY);
  assign in_fire     = in_bus.valid & in_ready_w;
  assign out_fire    = out_valid_w & out_bus.ready;

  assign in_bus.ready  = in_ready_w;
  assign out_bus.valid = out_valid_w;
  assign out_bus.data  = main_data;
  assign out_bus.ctrl  = out_valid_w ? main_ctrl : '0;
  assign level         = state;

  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(state);
  assign drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      // Payloads are kept; only control is cleared so a bubble carries no ctrl.
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      drop_cnt  <= drop_next;
    end else begin
      if (out_valid_w && !out_bus.ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_bus.data;
            main_ctrl <= in_bus.ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_data <= in_bus.data;
            skid_ctrl <= in_bus.ctrl;
            state     <= TWO;
          end else if (!in_fire && out_fire) begin
            main_ctrl <= '0;
            state     <= EMPTY;
          end else if (in_fire && out_fire) begin
            main_data <= in_bus.data;
            main_ctrl <= in_bus.ctrl;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - vector table, corner sequences and random scoreboard for pipe_skid_stage
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        flush_s;
  logic [1:0]  level, s_level;
  logic [15:0] stall_cnt, drop_cnt;
  logic [1:0]  s_stall, s_drop;

  pipe_skid_stage_if #(.DATA_W(32), .CTRL_W(8)) in_bus ();
  pipe_skid_stage_if #(.DATA_W(32), .CTRL_W(8)) out_bus ();
  pipe_skid_stage_if #(.DATA_W(32), .CTRL_W(8)) s_in ();
  pipe_skid_stage_if #(.DATA_W(32), .CTRL_W(8)) s_out ();

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_bus(in_bus), .out_bus(out_bus),
    .level(level), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .flush(flush_s),
    .in_bus(s_in), .out_bus(s_out),
    .level(s_level), .stall_cnt(s_stall), .drop_cnt(s_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic        ordy;
    logic        fl;
    logic [1:0]  lvl;
    logic        ov;
    logic [31:0] od;
    logic [7:0]  oc;
    logic        ir;
    int          st;
    int          dr;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[18];
  ent_t q[$];
  int   exp_st[5];

  initial begin
    // iv  d         c      or   fl  | lvl ov  od        oc     ir   st drop
    tbl[0]  = '{1'b1, 32'h1,    8'h01, 1'b1, 1'b0, 2'd1, 1'b1, 32'h1,  8'h01, 1'b1, 0, 0};
    tbl[1]  = '{1'b1, 32'h2,    8'h02, 1'b1, 1'b0, 2'd1, 1'b1, 32'h2,  8'h02, 1'b1, 0, 0};
    tbl[2]  = '{1'b1, 32'h3,    8'h03, 1'b1, 1'b0, 2'd1, 1'b1, 32'h3,  8'h03, 1'b1, 0, 0};
    tbl[3]  = '{1'b0, 32'h0,    8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  8'h00, 1'b1, 0, 0};
    tbl[4]  = '{1'b1, 32'hA,    8'h0A, 1'b0, 1'b0, 2'd1, 1'b1, 32'hA,  8'h0A, 1'b1, 0, 0};
    tbl[5]  = '{1'b1, 32'hB,    8'h0B, 1'b0, 1'b0, 2'd2, 1'b1, 32'hA,  8'h0A, 1'b0, 1, 0};
    tbl[6]  = '{1'b1, 32'hC,    8'h0C, 1'b0, 1'b0, 2'd2, 1'b1, 32'hA,  8'h0A, 1'b0, 2, 0};
    tbl[7]  = '{1'b0, 32'h0,    8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 32'hA,  8'h0A, 1'b0, 3, 0};
    tbl[8]  = '{1'b0, 32'h0,    8'h00, 1'b1, 1'b0, 2'd1, 1'b1, 32'hB,  8'h0B, 1'b1, 3, 0};
    tbl[9]  = '{1'b0, 32'h0,    8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  8'h00, 1'b1, 3, 0};
    tbl[10] = '{1'b1, 32'h10,   8'h10, 1'b0, 1'b0, 2'd1, 1'b1, 32'h10, 8'h10, 1'b1, 3, 0};
    tbl[11] = '{1'b1, 32'h11,   8'h11, 1'b0, 1'b0, 2'd2, 1'b1, 32'h10, 8'h10, 1'b0, 4, 0};
    tbl[12] = '{1'b1, 32'h12,   8'h12, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,  8'h00, 1'b1, 4, 2};
    tbl[13] = '{1'b0, 32'h0,    8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  8'h00, 1'b1, 4, 2};
    tbl[14] = '{1'b1, 32'h20,   8'h21, 1'b1, 1'b0, 2'd1, 1'b1, 32'h20, 8'h21, 1'b1, 4, 2};
    tbl[15] = '{1'b1, 32'h22,   8'h22, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,  8'h00, 1'b1, 4, 3};
    tbl[16] = '{1'b0, 32'hDEAD, 8'hFF, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  8'h00, 1'b1, 4, 3};
    tbl[17] = '{1'b0, 32'h0,    8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,  8'h00, 1'b1, 4, 3};
    exp_st = '{1, 2, 3, 3, 3};

    reset = 1'b0; flush = 1'b0; flush_s = 1'b0;
    in_bus.valid = 1'b0; in_bus.data = '0; in_bus.ctrl = '0; out_bus.ready = 1'b1;
    s_in.valid = 1'b0; s_in.data = '0; s_in.ctrl = '0; s_out.ready = 1'b1;
    step(); step();
    chk("rst.level", 32'(level), 32'd0);
    chk("rst.out_valid", 32'(out_bus.valid), 32'd0);
    chk("rst.out_ctrl", 32'(out_bus.ctrl), 32'd0);
    chk("rst.in_ready", 32'(in_bus.ready), 32'd1);
    chk("rst.stall", 32'(stall_cnt), 32'd0);
    chk("rst.drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 18; i++) begin
      in_bus.valid = tbl[i].iv; in_bus.data = tbl[i].d; in_bus.ctrl = tbl[i].c;
      out_bus.ready = tbl[i].ordy; flush = tbl[i].fl;
      step();
      chk($sformatf("v%0d.level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d.out_valid", i), 32'(out_bus.valid), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("v%0d.out_data", i), out_bus.data, tbl[i].od);
      chk($sformatf("v%0d.out_ctrl", i), 32'(out_bus.ctrl), 32'(tbl[i].oc));
      chk($sformatf("v%0d.in_ready", i), 32'(in_bus.ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d.stall", i), 32'(stall_cnt), 32'(tbl[i].st));
      chk($sformatf("v%0d.drop", i), 32'(drop_cnt), 32'(tbl[i].dr));
    end
    in_bus.valid = 1'b0; flush = 1'b0;

    // Reset while holding two entries with stall_cnt=5, flush and handshakes active.
    reset = 1'b0; step(); reset = 1'b1;
    out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = 32'h41; in_bus.ctrl = 8'h41; step();
    in_bus.data = 32'h42; in_bus.ctrl = 8'h42; step();
    in_bus.valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid.level", 32'(level), 32'd2);
    chk("mid.stall", 32'(stall_cnt), 32'd5);
    reset = 1'b0; flush = 1'b1; in_bus.valid = 1'b1; out_bus.ready = 1'b1;
    step();
    chk("mrst.level", 32'(level), 32'd0);
    chk("mrst.out_valid", 32'(out_bus.valid), 32'd0);
    chk("mrst.out_ctrl", 32'(out_bus.ctrl), 32'd0);
    chk("mrst.out_data", out_bus.data, 32'd0);
    chk("mrst.in_ready", 32'(in_bus.ready), 32'd1);
    chk("mrst.stall", 32'(stall_cnt), 32'd0);
    chk("mrst.drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1; flush = 1'b0; in_bus.valid = 1'b0;
    step();
    chk("mrst2.drop", 32'(drop_cnt), 32'd0);
    chk("mrst2.level", 32'(level), 32'd0);

    // Narrow counters saturate instead of wrapping.
    s_out.ready = 1'b0;
    s_in.valid = 1'b1; s_in.data = 32'h5; s_in.ctrl = 8'h5; step();
    s_in.valid = 1'b0;
    chk("sat.level1", 32'(s_level), 32'd1);
    chk("sat.stall0", 32'(s_stall), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("sat.stall%0d", k + 1), 32'(s_stall), 32'(exp_st[k]));
    end
    s_in.valid = 1'b1; s_in.data = 32'h6; step();
    s_in.valid = 1'b0;
    chk("sat.level2", 32'(s_level), 32'd2);
    flush_s = 1'b1; step(); flush_s = 1'b0;
    chk("sat.drop2", 32'(s_drop), 32'd2);
    chk("sat.flush_level", 32'(s_level), 32'd0);
    s_in.valid = 1'b1; step(); step();
    s_in.valid = 1'b0;
    chk("sat.refill", 32'(s_level), 32'd2);
    flush_s = 1'b1; step(); flush_s = 1'b0;
    chk("sat.drop_sat", 32'(s_drop), 32'd3);

    // Random traffic against a queue model.
    begin
      int   seq;
      int   mdl_stall;
      int   mdl_drop;
      logic ir_before;
      logic iv, ordy, fl;
      seq = 1; mdl_stall = 0; mdl_drop = 0;
      reset = 1'b0; step(); reset = 1'b1;
      q.delete();
      for (int n = 0; n < 10000; n++) begin
        ir_before = in_bus.ready;
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        fl   = ($urandom_range(0, 31) == 0);
        in_bus.valid = iv; in_bus.data = 32'(seq); in_bus.ctrl = 8'($urandom);
        out_bus.ready = ordy; flush = fl;
        #1;
        chk("rnd.in_ready_comb", 32'(in_bus.ready), 32'(ir_before));
        chk("rnd.in_ready", 32'(in_bus.ready), 32'(q.size() != 2));
        chk("rnd.level", 32'(level), 32'(q.size()));
        chk("rnd.out_valid", 32'(out_bus.valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("rnd.out_data", out_bus.data, q[0].d);
          chk("rnd.out_ctrl", 32'(out_bus.ctrl), 32'(q[0].c));
        end else begin
          chk("rnd.bubble_ctrl", 32'(out_bus.ctrl), 32'd0);
        end
        if (fl) begin
          mdl_drop += q.size();
          q.delete();
        end else begin
          logic acc;
          acc = iv && (q.size() != 2);
          if (q.size() != 0 && !ordy) mdl_stall++;
          if (q.size() != 0 && ordy) void'(q.pop_front());
          if (acc) begin
            q.push_back('{d: 32'(seq), c: in_bus.ctrl});
            seq++;
          end
        end
        @(posedge clk);
        #1;
      end
      in_bus.valid = 1'b0; flush = 1'b0;
      chk("rnd.stall_total", 32'(stall_cnt), 32'(mdl_stall));
      chk("rnd.drop_total", 32'(drop_cnt), 32'(mdl_drop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
